// File: rtl/booth_ctrl.sv
// Radix-4 Booth multiplier: sequencing controller plus the datapath it drives.
//
// booth_ctrl ports:
//   clk, rst_n        single clock, async active-low reset
//   in_valid/in_ready operand handshake (accept only in IDLE)
//   in_a, in_b        signed multiplicand / multiplier
//   mul_multiplicand  registered operands held stable for the whole op
//   mul_multiplier
//   mul_load          datapath load strobe (A, S, P)
//   mul_en_inp        stage-1 enable: partial-product select register
//   mul_en_p          stage-2 enable: accumulate + arithmetic shift by 2
//   mul_product       product bus from the datapath
//   out_valid/ready   result handshake; out_product held while stalled
//   busy              high whenever not IDLE
//
// booth_datapath ports:
//   clk, rst_n, load, en_inp, en_p, multiplicand, multiplier -> product

module booth_datapath #(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           en_inp,
  input  logic           en_p,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product
);
  // Two guard bits: |acc + 2M| stays below 2^(W+1), so W+2 signed bits suffice.
  localparam int HW = W + 2;

  logic signed [HW-1:0] a_r, s_r, pp, h, sel, sum;
  logic [W-1:0]         l;
  logic                 q;
  logic [HW+W:0]        shifted;
  logic                 unused_bits;

  always_comb begin
    sel = '0;
    case ({l[1:0], q})
      3'b001, 3'b010: sel = a_r;
      3'b011:         sel = a_r <<< 1;
      3'b100:         sel = s_r <<< 1;
      3'b101, 3'b110: sel = s_r;
      default:        sel = '0;
    endcase
    sum     = h + pp;
    shifted = $signed({sum, l, q}) >>> 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      s_r <= '0;
      pp  <= '0;
      h   <= '0;
      l   <= '0;
      q   <= 1'b0;
    end else if (load) begin
      a_r <= HW'($signed(multiplicand));
      s_r <= -HW'($signed(multiplicand));
      pp  <= '0;
      h   <= '0;
      l   <= multiplier;
      q   <= 1'b0;
    end else begin
      if (en_inp) pp <= sel;
      if (en_p) {h, l, q} <= shifted;
    end
  end

  assign product     = {h[W-1:0], l};
  assign unused_bits = ^{h[HW-1:W], q};
endmodule

module booth_ctrl #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 12,
  parameter int ITERATIONS   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_a,
  input  logic [INPUT_WIDTH-1:0]  in_b,
  output logic [INPUT_WIDTH-1:0]  mul_multiplicand,
  output logic [INPUT_WIDTH-1:0]  mul_multiplier,
  output logic                    mul_load,
  output logic                    mul_en_inp,
  output logic                    mul_en_p,
  input  logic [OUTPUT_WIDTH-1:0] mul_product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_product,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, LOAD, PREP, ACC, CAPT, OUT} state_t;

  localparam logic [1:0] LAST_ITER = 2'(ITERATIONS - 1);

  state_t     state, state_nx;
  logic [1:0] iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      iter             <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      out_product      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        mul_multiplicand <= in_a;
        mul_multiplier   <= in_b;
        iter             <= '0;
      end
      if (state == ACC && iter != LAST_ITER) iter <= iter + 2'd1;
      if (state == CAPT) out_product <= mul_product;
    end
  end

  // Every output is a pure state decode, so out_ready never reaches in_ready
  // combinationally and the datapath strobes are one-hot by construction.
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    mul_load   = 1'b0;
    mul_en_inp = 1'b0;
    mul_en_p   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = LOAD;
      end
      LOAD: begin
        mul_load = 1'b1;
        state_nx = PREP;
      end
      PREP: begin
        mul_en_inp = 1'b1;
        state_nx   = ACC;
      end
      ACC: begin
        mul_en_p = 1'b1;
        state_nx = (iter == LAST_ITER) ? CAPT : PREP;
      end
      CAPT: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl driving booth_datapath.
module tb_booth_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [5:0]  in_a, in_b, mul_multiplicand, mul_multiplier;
  logic        mul_load, mul_en_inp, mul_en_p;
  logic [11:0] mul_product, out_product;

  int vecs = 0;
  int errs = 0;

  logic [2:0] exp_str [8] = '{3'b100, 3'b010, 3'b001, 3'b010,
                              3'b001, 3'b010, 3'b001, 3'b000};

  always #5 clk = ~clk;

  booth_ctrl #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(12), .ITERATIONS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_load(mul_load), .mul_en_inp(mul_en_inp), .mul_en_p(mul_en_p),
    .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy)
  );

  booth_datapath #(.W(6)) dp (
    .clk(clk), .rst_n(rst_n),
    .load(mul_load), .en_inp(mul_en_inp), .en_p(mul_en_p),
    .multiplicand(mul_multiplicand), .multiplier(mul_multiplier),
    .product(mul_product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand pair through the handshake and returns the product
  // observed on the first out_valid cycle; the caller owns out_ready.
  task automatic do_op(input int a, input int b, output logic [11:0] prod,
                       output bit tmo);
    int n;
    tmo = 1'b0;
    in_a = 6'(a); in_b = 6'(b); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) tmo = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) tmo = 1'b1;
    prod = out_product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    #3;
    vecs++;
    if ({in_ready, busy, out_valid, mul_load, mul_en_inp, mul_en_p} !== 6'b100000) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 100000",
               {in_ready, busy, out_valid, mul_load, mul_en_inp, mul_en_p});
    end
    vecs++;
    if ({mul_multiplicand, mul_multiplier, out_product} !== 24'h0) begin
      errs++;
      $display("FAIL reset_data: got %h want 000000",
               {mul_multiplicand, mul_multiplier, out_product});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    vecs++;
    if ({in_ready, busy} !== 2'b10) begin
      errs++; $display("FAIL idle_after_reset: got %b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_a = 6'd5; in_b = 6'(-3); in_valid = 1'b1;
    tick();                       // handshake edge
    in_valid = 1'b0;
    vecs++;
    if ({mul_multiplicand, mul_multiplier} !== {6'd5, 6'h3D}) begin
      errs++;
      $display("FAIL single_operands: got %h want %h",
               {mul_multiplicand, mul_multiplier}, {6'd5, 6'h3D});
    end
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if ({mul_load, mul_en_inp, mul_en_p, out_valid} !== {exp_str[k], 1'b0}) begin
        errs++;
        $display("FAIL single_strobe[%0d]: got %b want %b", k,
                 {mul_load, mul_en_inp, mul_en_p, out_valid}, {exp_str[k], 1'b0});
      end
      tick();
    end
    vecs++;
    if ({out_valid, out_product} !== {1'b1, 12'hFF1}) begin
      errs++;
      $display("FAIL single_result: got %b/%h want 1/ff1", out_valid, out_product);
    end
    tick();
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++; $display("FAIL single_return: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_corners();
    int          ca [5] = '{-32, -32, 31,  0, -1};
    int          cb [5] = '{-32,  31, 31, -17, -1};
    logic [11:0] ce [5] = '{12'h400, 12'hC20, 12'h3C1, 12'h000, 12'h001};
    logic [11:0] p;
    bit          tmo;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_op(ca[i], cb[i], p, tmo);
      vecs++;
      if (tmo || p !== ce[i]) begin
        errs++;
        $display("FAIL corner[%0d] %0d*%0d: got %h (timeout %0d) want %h",
                 i, ca[i], cb[i], p, tmo, ce[i]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [11:0] p;
    bit          tmo;
    out_ready = 1'b0;
    do_op(-7, 9, p, tmo);
    vecs++;
    if (tmo || p !== 12'hFC1) begin
      errs++; $display("FAIL bp_result: got %h (timeout %0d) want fc1", p, tmo);
    end
    in_a = 6'd3; in_b = 6'd3; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      vecs++;
      if ({out_valid, in_ready, out_product, mul_multiplicand} !==
          {1'b1, 1'b0, 12'hFC1, 6'h39}) begin
        errs++;
        $display("FAIL bp_hold[%0d]: got %b %b %h %h want 1 0 fc1 39", k,
                 out_valid, in_ready, out_product, mul_multiplicand);
      end
    end
    out_ready = 1'b1;
    tick();
    vecs++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errs++; $display("FAIL bp_release: got %b want 100", {in_ready, busy, out_valid});
    end
    tick();                       // pending offer now accepted
    in_valid = 1'b0;
    vecs++;
    if ({mul_load, mul_multiplicand} !== {1'b1, 6'd3}) begin
      errs++;
      $display("FAIL bp_accept: got %b/%h want 1/03", mul_load, mul_multiplicand);
    end
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    vecs++;
    if ({out_valid, out_product} !== {1'b1, 12'h009}) begin
      errs++; $display("FAIL bp_next: got %b/%h want 1/009", out_valid, out_product);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    in_a = 6'd11; in_b = 6'(-5); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();   // LOAD, PREP, ACC, PREP -> second ACC
    vecs++;
    if ({mul_load, mul_en_inp, mul_en_p} !== 3'b001) begin
      errs++;
      $display("FAIL mid_second_acc: got %b want 001", {mul_load, mul_en_inp, mul_en_p});
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({in_ready, busy, out_valid, mul_load, mul_en_inp, mul_en_p,
         mul_multiplicand, mul_multiplier, out_product} !== {6'b100000, 24'h0}) begin
      errs++;
      $display("FAIL mid_async_reset: got %b %h want 100000 000000",
               {in_ready, busy, out_valid, mul_load, mul_en_inp, mul_en_p},
               {mul_multiplicand, mul_multiplier, out_product});
    end
    in_a = 6'd7; in_b = 6'd7; in_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();                       // first edge out of reset takes the offer
    in_valid = 1'b0;
    vecs++;
    if ({mul_load, mul_multiplicand, mul_multiplier} !== {1'b1, 6'd7, 6'd7}) begin
      errs++;
      $display("FAIL post_reset_accept: got %b/%h/%h want 1/07/07",
               mul_load, mul_multiplicand, mul_multiplier);
    end
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    vecs++;
    if ({out_valid, out_product} !== {1'b1, 12'h031}) begin
      errs++; $display("FAIL post_reset_op: got %b/%h want 1/031", out_valid, out_product);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int          strobe_err = 0;
    int          hold_err   = 0;
    int          n;
    logic [11:0] exp_p, held;
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        exp_p = 12'(a * b);
        in_a = 6'(a); in_b = 6'(b); in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
          out_ready = 1'($urandom_range(0, 1)); tick(); n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
          if ($countones({mul_load, mul_en_inp, mul_en_p}) > 1) strobe_err++;
          out_ready = 1'($urandom_range(0, 1));
          tick(); n++;
        end
        vecs++;
        if (!out_valid || out_product !== exp_p) begin
          errs++;
          $display("FAIL exh %0d*%0d: got %b/%h want 1/%h", a, b,
                   out_valid, out_product, exp_p);
        end
        held = out_product;
        out_ready = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_ready && n < 50) begin
          tick(); n++;
          if (!out_valid || out_product !== held ||
              (mul_load | mul_en_inp | mul_en_p)) hold_err++;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        tick();
      end
    end
    vecs++;
    if (strobe_err !== 0) begin
      errs++; $display("FAIL exh_strobes: got %0d overlaps want 0", strobe_err);
    end
    vecs++;
    if (hold_err !== 0) begin
      errs++; $display("FAIL exh_hold: got %0d unstable cycles want 0", hold_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_backpressure();
    test_reset_mid_op();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
